// File: rtl/mem_dec_pkg.sv
// Shared definitions for the banked-memory decoder.
//   CNT_W      : width of the rd/wr access counters
//   TAG_BANK_W : bank-index width held in a read tag (upper bound on BANK_W)
//   rd_tag_t   : {valid, bank index} carried down the read-tag pipeline
//   num_banks(): bank count derived from the bank-select width
package mem_dec_pkg;

    localparam int CNT_W      = 16;
    localparam int TAG_BANK_W = 8;

    typedef struct packed {
        logic                  valid;
        logic [TAG_BANK_W-1:0] bank;
    } rd_tag_t;

    function automatic int num_banks(input int bank_w);
        return 1 << bank_w;
    endfunction

endpackage

// File: rtl/mem_dec_tag_pipe.sv
// Read-tag delay line: RD_LAT registered stages so that a tag pushed in the
// bank_cs cycle pops out exactly RD_LAT cycles later.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset, invalidates every stage
//   tag_in  : tag pushed every cycle (invalid for writes/idle)
//   tag_out : tag leaving the last stage
module mem_dec_tag_pipe
    import mem_dec_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("mem_dec_tag_pipe: RD_LAT must be in 1..4");
    end

    rd_tag_t stage_reg [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_reg[i] <= '0;
            end
        end else begin
            stage_reg[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign tag_out = stage_reg[RD_LAT-1];

endmodule

// File: rtl/mem_bank_dec.sv
// Banked-memory request decoder with in-order read-response steering.
// Optional feature macro: MEM_BANK_DEC_CNT_EN builds saturating 16-bit
// read/write access counters; when undefined rd_cnt/wr_cnt are tied to 0.
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   req_valid    : access request this cycle
//   req_we       : 1 = write, 0 = read
//   req_addr     : word address, top BANK_W bits select the bank
//   req_wdata    : write data
//   bank_cs      : registered one-hot bank chip-select
//   bank_we      : registered write enable (common to all banks)
//   bank_addr    : registered in-bank address
//   bank_wdata   : registered write data
//   bank_rdata   : concatenated bank read data, bank k at [k*DATA_W +: DATA_W]
//   rsp_valid    : read data valid, RD_LAT cycles after the read's bank_cs
//   rsp_rdata    : read data from the tagged bank, 0 when not valid
//   rd_cnt/wr_cnt: accepted read/write counters
module mem_bank_dec
    import mem_dec_pkg::*;
#(
    parameter  int ADDR_W    = 12,
    parameter  int BANK_W    = 2,
    parameter  int DATA_W    = 8,
    parameter  int RD_LAT    = 1,
    localparam int NUM_BANKS = num_banks(BANK_W),
    localparam int IN_W      = ADDR_W - BANK_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    input  logic                        req_we,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [DATA_W-1:0]           req_wdata,
    output logic [NUM_BANKS-1:0]        bank_cs,
    output logic                        bank_we,
    output logic [IN_W-1:0]             bank_addr,
    output logic [DATA_W-1:0]           bank_wdata,
    input  logic [NUM_BANKS*DATA_W-1:0] bank_rdata,
    output logic                        rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic [CNT_W-1:0]            rd_cnt,
    output logic [CNT_W-1:0]            wr_cnt
);

    if (BANK_W < 1 || BANK_W > TAG_BANK_W) begin : g_bad_bank_w
        $error("mem_bank_dec: BANK_W out of supported range");
    end

    // ------------------------------------------------------------------
    // Request stage
    // ------------------------------------------------------------------
    logic [BANK_W-1:0]    req_bank;
    logic [NUM_BANKS-1:0] cs_next;

    assign req_bank = req_addr[ADDR_W-1 -: BANK_W];

    // One comparator per bank keeps the select strictly one-hot or zero.
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_cs_dec
        assign cs_next[gi] = req_valid && (req_bank == BANK_W'(gi));
    end

    logic [NUM_BANKS-1:0] bank_cs_reg;
    logic                 bank_we_reg;
    logic [IN_W-1:0]      bank_addr_reg;
    logic [DATA_W-1:0]    bank_wdata_reg;
    logic [BANK_W-1:0]    bank_idx_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_cs_reg    <= '0;
            bank_we_reg    <= 1'b0;
            bank_addr_reg  <= '0;
            bank_wdata_reg <= '0;
            bank_idx_reg   <= '0;
        end else begin
            bank_cs_reg <= cs_next;
            // Gating with req_valid keeps bank_we low whenever no bank is selected.
            bank_we_reg <= req_valid && req_we;
            if (req_valid) begin
                bank_addr_reg  <= req_addr[IN_W-1:0];
                bank_wdata_reg <= req_wdata;
                bank_idx_reg   <= req_bank;
            end
        end
    end

    assign bank_cs    = bank_cs_reg;
    assign bank_we    = bank_we_reg;
    assign bank_addr  = bank_addr_reg;
    assign bank_wdata = bank_wdata_reg;

    // ------------------------------------------------------------------
    // Read-tag pipeline: the tag is pushed from the bank_cs cycle so that
    // RD_LAT stages place rsp_valid exactly RD_LAT cycles after bank_cs.
    // ------------------------------------------------------------------
    rd_tag_t tag_in;
    rd_tag_t tag_out;

    assign tag_in.valid = (|bank_cs_reg) && !bank_we_reg;
    assign tag_in.bank  = TAG_BANK_W'(bank_idx_reg);

    mem_dec_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // ------------------------------------------------------------------
    // Response steering: compare against the full tag field so that an
    // out-of-range tag can never alias onto a real bank.
    // ------------------------------------------------------------------
    logic [NUM_BANKS-1:0] rsp_sel;

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_rsp_sel
        assign rsp_sel[gi] = tag_out.valid && (tag_out.bank == TAG_BANK_W'(gi));
    end

    always_comb begin
        rsp_rdata = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (rsp_sel[k]) begin
                rsp_rdata = rsp_rdata | bank_rdata[k*DATA_W +: DATA_W];
            end
        end
    end

    assign rsp_valid = tag_out.valid;

    // ------------------------------------------------------------------
    // Access counters
    // ------------------------------------------------------------------
`ifdef MEM_BANK_DEC_CNT_EN
    logic [CNT_W-1:0] rd_cnt_reg;
    logic [CNT_W-1:0] wr_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_reg <= '0;
            wr_cnt_reg <= '0;
        end else begin
            if (req_valid && !req_we && (rd_cnt_reg != '1)) begin
                rd_cnt_reg <= rd_cnt_reg + CNT_W'(1);
            end
            if (req_valid && req_we && (wr_cnt_reg != '1)) begin
                wr_cnt_reg <= wr_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign rd_cnt = rd_cnt_reg;
    assign wr_cnt = wr_cnt_reg;
`else
    assign rd_cnt = '0;
    assign wr_cnt = '0;
`endif

endmodule

// File: doc/mem_bank_dec.md
MEM_BANK_DEC -- requirements
Module: mem_bank_dec

Interface
REQ-001 Parameter ADDR_W, default 12, total word-address width of the banked memory.
REQ-002 Parameter BANK_W, default 2, bank-select width; NUM_BANKS = 2**BANK_W.
REQ-003 Parameter DATA_W, default 8, data width per bank.
REQ-004 Parameter RD_LAT, default 1, bank read latency in cycles after bank_cs; legal range 1..4.
REQ-005 Port clk  in  1  single clock; all state on rising edge.
REQ-006 Port rst_n  in  1  asynchronous active-low reset.
REQ-007 Port req_valid  in  1  access request this cycle.
REQ-008 Port req_we  in  1  1 = write, 0 = read.
REQ-009 Port req_addr  in  ADDR_W  word address; top BANK_W bits select the bank.
REQ-010 Port req_wdata  in  DATA_W  write data.
REQ-011 Port bank_cs  out  NUM_BANKS  registered one-hot bank chip-select.
REQ-012 Port bank_we  out  1  registered write enable, common to all banks.
REQ-013 Port bank_addr  out  ADDR_W-BANK_W  registered in-bank address, low bits of req_addr.
REQ-014 Port bank_wdata  out  DATA_W  registered write data.
REQ-015 Port bank_rdata  in  NUM_BANKS*DATA_W  concatenated bank read data; bank k occupies slice [k*DATA_W +: DATA_W].
REQ-016 Port rsp_valid  out  1  read data valid.
REQ-017 Port rsp_rdata  out  DATA_W  read data returned from the addressed bank.
REQ-018 Port rd_cnt, wr_cnt  out  16 each  access counters; see Configuration.

Function
REQ-019 Request stage: bank_cs, bank_we, bank_addr and bank_wdata update one cycle after the req_valid edge; latency is exactly 1.
REQ-020 bank_cs shall be one-hot at bit req_addr[ADDR_W-1 -: BANK_W] when req_valid=1, all-zero otherwise; never more than one bit set.
REQ-021 bank_we shall be 0 whenever bank_cs is all-zero.
REQ-022 Each issued read shall push {valid, bank index} into a tag pipeline RD_LAT stages deep; writes and idle cycles push an invalid tag.
REQ-023 rsp_valid shall assert exactly RD_LAT cycles after the bank_cs cycle of the read; rsp_rdata shall be the bank_rdata slice of the tagged bank, sampled that cycle, combinationally muxed.
REQ-024 rsp_rdata shall be 0 when rsp_valid=0.
REQ-025 Back-to-back requests to any mix of banks, one per cycle, shall be accepted with no stall; responses return in issue order, one per cycle.
REQ-026 A read immediately following a write to the same address needs no special handling; ordering is guaranteed by the banks.
REQ-027 Address wrap: the highest address selects bank NUM_BANKS-1 with all-ones bank_addr; no out-of-range case exists.

Reset
REQ-028 Whenever rst_n=0: bank_cs=0, bank_we=0, bank_addr=0, bank_wdata=0, all tags invalid, rsp_valid=0, rsp_rdata=0, rd_cnt=0, wr_cnt=0.
REQ-029 Reset asserted mid-operation shall discard all in-flight reads; no rsp_valid pulse follows reset release unless caused by a new request.

Configuration
REQ-030 Macro MEM_BANK_DEC_CNT_EN defined: rd_cnt/wr_cnt increment by 1 on each accepted read/write and saturate at 16'hFFFF.
REQ-031 Macro MEM_BANK_DEC_CNT_EN undefined: no counter registers are built; rd_cnt and wr_cnt are tied to 0; all other behaviour is identical.

Structure
REQ-032 Package mem_dec_pkg shall hold the NUM_BANKS derivation function, the tag typedef {valid, bank index}, and the counter width constant (16).
REQ-033 Sub-module mem_dec_tag_pipe shall implement the RD_LAT-deep tag shift register with async active-low reset.

Verification
REQ-034 Default params, write 8'hA5 to 12'h000 then 12'hC01 -> bank_cs 4'b0001 then 4'b1000, bank_we=1, bank_addr 10'h000 then 10'h001, no rsp_valid.
REQ-035 Reads to 12'h400, 12'h800, 12'h000 back-to-back, bank k returning 8'h10+k -> rsp_valid for 3 consecutive cycles with data 8'h11, 8'h12, 8'h10, starting RD_LAT cycles after the first bank_cs.
REQ-036 RD_LAT=3, single read to bank 2 -> rsp_valid exactly 3 cycles after bank_cs=4'b0100, 0 in every other cycle.
REQ-037 rst_n pulsed low while 2 reads are in flight -> all outputs 0 immediately, no rsp_valid after release.
REQ-038 With MEM_BANK_DEC_CNT_EN, 70000 reads -> rd_cnt=16'hFFFF, wr_cnt=0; without the macro both stay 0.
REQ-039 BANK_W=3, ADDR_W=16, random traffic -> bank_cs always one-hot or zero, scoreboard matches every rsp_rdata.
